// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: byte stream in, MSB-first shift out, full-duplex byte capture.
// Byte time 16*DIV clks; cmd_ready only in IDLE/WAIT, WAIT holds CS low indefinitely.
module spi_master_ctrl #(
  parameter int DIV     = 4,
  parameter int CSS_CYC = 4,
  parameter int CSH_CYC = 4,
  parameter int GAP_CYC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic       cmd_last,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mo,
  input  logic       spi_mi
);

  localparam int MAX_A   = (DIV > CSS_CYC) ? DIV : CSS_CYC;
  localparam int MAX_B   = (CSH_CYC > GAP_CYC) ? CSH_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] DIV_END = CW'(DIV - 1);
  localparam logic [CW-1:0] CSS_END = CW'(CSS_CYC - 1);
  localparam logic [CW-1:0] CSH_END = CW'(CSH_CYC - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, WAIT, HOLD, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic          last_q;
  logic          ready_en;

  // ready_en keeps cmd_ready low for the first clk after reset release
  assign cmd_ready = ready_en && ((state == IDLE) || (state == WAIT));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= 3'd0;
      tx_sh    <= 8'h00;
      rx_sh    <= 8'h00;
      last_q   <= 1'b0;
      ready_en <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
      spi_sclk <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_mo   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            tx_sh    <= cmd_data;
            last_q   <= cmd_last;
            bit_cnt  <= 3'd7;
            spi_cs_n <= 1'b0;
            spi_mo   <= cmd_data[7];
            cnt      <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == CSS_END) begin
            cnt   <= '0;
            state <= LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOW: begin
          if (cnt == DIV_END) begin
            cnt      <= '0;
            spi_sclk <= 1'b1;
            rx_sh    <= {rx_sh[6:0], spi_mi};
            state    <= HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (cnt == DIV_END) begin
            cnt      <= '0;
            spi_sclk <= 1'b0;
            if (bit_cnt != 3'd0) begin
              bit_cnt <= bit_cnt - 3'd1;
              spi_mo  <= tx_sh[bit_cnt - 3'd1];
              state   <= LOW;
            end else begin
              rx_data  <= rx_sh;
              rx_valid <= 1'b1;
              state    <= last_q ? HOLD : WAIT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          // next byte of the same frame skips the CS setup delay
          if (cmd_valid && cmd_ready) begin
            tx_sh   <= cmd_data;
            last_q  <= cmd_last;
            bit_cnt <= 3'd7;
            spi_mo  <= cmd_data[7];
            cnt     <= '0;
            state   <= LOW;
          end
        end
        HOLD: begin
          spi_mo <= 1'b0;
          if (cnt == CSH_END) begin
            cnt      <= '0;
            spi_cs_n <= 1'b1;
            state    <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_END) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: slave model + rx scoreboard on a DIV=2 instance,
// loopback instances at DIV=3 and DIV=7 for the timing sweep.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  int         checks = 0;
  int         failures = 0;

  logic       cmd_valid = 1'b0;
  logic       cmd_last = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, rx_valid, busy, spi_sclk, spi_cs_n, spi_mo, spi_mi;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  spi_master_ctrl #(.DIV(2), .CSS_CYC(4), .CSH_CYC(4), .GAP_CYC(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_last(cmd_last), .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mo(spi_mo), .spi_mi(spi_mi)
  );

  // mode-0 slave: MSB ready at CS fall, next bit after each SCLK fall
  logic [7:0] slv_resp = 8'h00;
  logic [7:0] slv_sh = 8'h00;
  int         slv_bits = 0;
  logic       cs_d = 1'b1, sck_d = 1'b0;
  assign spi_mi = slv_sh[7];
  always @(posedge clk) begin
    cs_d  <= spi_cs_n;
    sck_d <= spi_sclk;
    if (cs_d && !spi_cs_n) begin
      slv_sh   <= slv_resp;
      slv_bits <= 0;
    end else if (sck_d && !spi_sclk && !spi_cs_n) begin
      if (slv_bits == 7) begin
        slv_sh   <= slv_resp;
        slv_bits <= 0;
      end else begin
        slv_sh   <= {slv_sh[6:0], 1'b0};
        slv_bits <= slv_bits + 1;
      end
    end
  end

  logic [63:0] mo_hist = '0;
  int          rise_cnt = 0;
  int          cs_rise = 0;
  always @(posedge spi_sclk) begin
    mo_hist  <= {mo_hist[62:0], spi_mo};
    rise_cnt <= rise_cnt + 1;
  end
  always @(posedge spi_cs_n) cs_rise <= cs_rise + 1;

  int hi_len = 0, last_hi_len = 0, gap_bad = 0;
  always @(negedge clk) begin
    if (spi_cs_n === 1'b1) begin
      if (hi_len < 8 && cmd_ready) gap_bad <= gap_bad + 1;
      hi_len <= hi_len + 1;
    end else begin
      if (hi_len != 0) last_hi_len <= hi_len;
      hi_len <= 0;
    end
  end

  // loopback sweep instances
  logic [1:0] sw_valid = '0, sw_last = '0;
  logic [7:0] sw_data [2] = '{8'h00, 8'h00};
  logic [1:0] sw_ready, sw_rxv, sw_busy, sw_sclk, sw_csn, sw_mo;
  logic [7:0] sw_rxd [2];
  int         sw_per_cnt [2], sw_per_bad [2];
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_sw
    localparam int D = (g == 0) ? 3 : 7;
    int   last_rise = 0, per_cnt = 0, per_bad = 0;
    logic have = 1'b0, sclk_d = 1'b0;
    spi_master_ctrl #(.DIV(D)) u_sw (
      .clk(clk), .rst_n(rst_n), .cmd_valid(sw_valid[g]), .cmd_ready(sw_ready[g]),
      .cmd_data(sw_data[g]), .cmd_last(sw_last[g]), .rx_valid(sw_rxv[g]), .rx_data(sw_rxd[g]),
      .busy(sw_busy[g]), .spi_sclk(sw_sclk[g]), .spi_cs_n(sw_csn[g]), .spi_mo(sw_mo[g]),
      .spi_mi(sw_mo[g])
    );
    always @(negedge clk) begin
      sclk_d <= sw_sclk[g];
      if (sw_csn[g]) begin
        have <= 1'b0;
      end else if (sw_sclk[g] && !sclk_d) begin
        if (have) begin
          per_cnt <= per_cnt + 1;
          if (cyc - last_rise != 2 * D) per_bad <= per_bad + 1;
        end
        have      <= 1'b1;
        last_rise <= cyc;
      end
    end
    assign sw_per_cnt[g] = per_cnt;
    assign sw_per_bad[g] = per_bad;
  end

  logic [7:0] sb_q[$];
  logic [7:0] sw_q[$];
  int         rx_count = 0;

  // every wait in the bench goes through here so no rx pulse is missed
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    if (rx_valid === 1'b1) begin
      rx_count++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL rx_unexpected got=%02h expected none", rx_data);
      end else begin
        e = sb_q.pop_front();
        if (rx_data !== e) begin
          failures++;
          $display("FAIL rx_data got=%02h exp=%02h", rx_data, e);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    step();
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_last  = l;
    sb_q.push_back(slv_resp);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL handshake_timeout cmd_ready=%b exp=1", cmd_ready);
    end
    @(posedge clk);
  endtask

  task automatic drop_valid();
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cs_high(output int n);
    n = 0;
    while (spi_cs_n !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    checks++;
    if (spi_cs_n !== 1'b1) begin
      failures++;
      $display("FAIL cs_release_timeout cs_n=%b exp=1", spi_cs_n);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (spi_sclk !== 1'b0)  begin failures++; $display("FAIL rst_sclk got=%b exp=0", spi_sclk); end
    if (spi_cs_n !== 1'b1)  begin failures++; $display("FAIL rst_cs_n got=%b exp=1", spi_cs_n); end
    if (spi_mo !== 1'b0)    begin failures++; $display("FAIL rst_mo got=%b exp=0", spi_mo); end
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", cmd_ready); end
    if (rx_valid !== 1'b0)  begin failures++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
    if (rx_data !== 8'h00)  begin failures++; $display("FAIL rst_rx_data got=%02h exp=00", rx_data); end
    if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    step();
    step();
    checks += 2;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", cmd_ready); end
    if (busy !== 1'b0)      begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    int n, r0, k0;
    logic [7:0] d;
    d = 8'hA5;
    slv_resp = 8'h3C;
    r0 = rx_count;
    k0 = rise_cnt;
    send_byte(d, 1'b1);
    drop_valid();
    wait_cs_high(n);
    checks += 5;
    if (n != 40) begin failures++; $display("FAIL single_cs_low got=%0d exp=40", n); end
    if (rise_cnt - k0 != 8) begin failures++; $display("FAIL single_pulses got=%0d exp=8", rise_cnt - k0); end
    if (mo_hist[7:0] !== d) begin failures++; $display("FAIL single_mo_bits got=%02h exp=%02h", mo_hist[7:0], d); end
    if (rx_count - r0 != 1) begin failures++; $display("FAIL single_rx_count got=%0d exp=1", rx_count - r0); end
    if (sb_q.size() != 0) begin failures++; $display("FAIL single_sb_left got=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_burst();
    int n, r0, k0, c0;
    slv_resp = 8'h5A;
    r0 = rx_count;
    k0 = rise_cnt;
    c0 = cs_rise;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b1);
    drop_valid();
    checks++;
    if (cs_rise != c0) begin failures++; $display("FAIL burst_cs_mid got=%0d rises exp=0", cs_rise - c0); end
    wait_cs_high(n);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks += 6;
    if (n != 8) begin failures++; $display("FAIL burst_gap got=%0d exp=8", n); end
    if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL burst_gap_cs got=%b exp=1", spi_cs_n); end
    if (rise_cnt - k0 != 24) begin failures++; $display("FAIL burst_pulses got=%0d exp=24", rise_cnt - k0); end
    if (mo_hist[23:0] !== 24'h010203) begin failures++; $display("FAIL burst_mo got=%06h exp=010203", mo_hist[23:0]); end
    if (rx_count - r0 != 3) begin failures++; $display("FAIL burst_rx_count got=%0d exp=3", rx_count - r0); end
    if (cs_rise - c0 != 1) begin failures++; $display("FAIL burst_cs_rises got=%0d exp=1", cs_rise - c0); end
  endtask

  task automatic test_wait();
    int n, r0, bad;
    slv_resp = 8'hC3;
    r0 = rx_count;
    send_byte(8'h55, 1'b0);
    drop_valid();
    n = 0;
    while (cmd_ready !== 1'b1 && n < 500) begin
      step();
      n++;
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (spi_cs_n !== 1'b0 || spi_sclk !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b1) bad++;
      step();
    end
    checks += 2;
    if (bad != 0) begin failures++; $display("FAIL wait_hold got=%0d bad cycles exp=0", bad); end
    if (rx_count - r0 != 1) begin failures++; $display("FAIL wait_rx_first got=%0d exp=1", rx_count - r0); end
    send_byte(8'hAA, 1'b1);
    drop_valid();
    wait_cs_high(n);
    checks += 3;
    if (rx_count - r0 != 2) begin failures++; $display("FAIL wait_rx_total got=%0d exp=2", rx_count - r0); end
    if (mo_hist[15:0] !== 16'h55AA) begin failures++; $display("FAIL wait_mo got=%04h exp=55aa", mo_hist[15:0]); end
    if (sb_q.size() != 0) begin failures++; $display("FAIL wait_sb_left got=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_reset_abort();
    int n, r0, k0;
    logic [7:0] d;
    slv_resp = 8'h99;
    r0 = rx_count;
    k0 = rise_cnt;
    send_byte(8'hF0, 1'b1);
    drop_valid();
    n = 0;
    while (rise_cnt - k0 < 4 && n < 500) begin
      step();
      n++;
    end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL abort_cs_n got=%b exp=1", spi_cs_n); end
    if (spi_sclk !== 1'b0) begin failures++; $display("FAIL abort_sclk got=%b exp=0", spi_sclk); end
    if (spi_mo !== 1'b0)   begin failures++; $display("FAIL abort_mo got=%b exp=0", spi_mo); end
    if (busy !== 1'b0)     begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    sb_q.delete();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (rx_count != r0) begin failures++; $display("FAIL abort_rx got=%0d pulses exp=0", rx_count - r0); end
    d = 8'h0F;
    slv_resp = 8'h81;
    r0 = rx_count;
    k0 = rise_cnt;
    send_byte(d, 1'b1);
    drop_valid();
    wait_cs_high(n);
    checks += 4;
    if (n != 40) begin failures++; $display("FAIL after_abort_cs_low got=%0d exp=40", n); end
    if (rise_cnt - k0 != 8) begin failures++; $display("FAIL after_abort_pulses got=%0d exp=8", rise_cnt - k0); end
    if (mo_hist[7:0] !== d) begin failures++; $display("FAIL after_abort_mo got=%02h exp=%02h", mo_hist[7:0], d); end
    if (rx_count - r0 != 1) begin failures++; $display("FAIL after_abort_rx got=%0d exp=1", rx_count - r0); end
  endtask

  task automatic test_back_to_back();
    int n, r0, g0;
    slv_resp = 8'h66;
    r0 = rx_count;
    g0 = gap_bad;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    drop_valid();
    wait_cs_high(n);
    checks += 4;
    if (last_hi_len < 8) begin failures++; $display("FAIL b2b_gap got=%0d exp>=8", last_hi_len); end
    if (gap_bad != g0) begin failures++; $display("FAIL b2b_ready_in_gap got=%0d exp=0", gap_bad - g0); end
    if (rx_count - r0 != 2) begin failures++; $display("FAIL b2b_rx got=%0d exp=2", rx_count - r0); end
    if (mo_hist[15:0] !== 16'h1122) begin failures++; $display("FAIL b2b_mo got=%04h exp=1122", mo_hist[15:0]); end
  endtask

  task automatic test_div_sweep();
    int n, pc0, pb0;
    logic [7:0] d, e;
    for (int k = 0; k < 2; k++) begin
      pc0 = sw_per_cnt[k];
      pb0 = sw_per_bad[k];
      for (int i = 0; i < 4; i++) begin
        d = 8'($urandom_range(0, 255));
        sw_q.push_back(d);
        step();
        sw_valid[k] = 1'b1;
        sw_data[k]  = d;
        sw_last[k]  = 1'b1;
        n = 0;
        while (sw_ready[k] !== 1'b1 && n < 1000) begin
          step();
          n++;
        end
        @(posedge clk);
        step();
        sw_valid[k] = 1'b0;
        n = 0;
        while (sw_rxv[k] !== 1'b1 && n < 1000) begin
          step();
          n++;
        end
        e = sw_q.pop_front();
        checks++;
        if (sw_rxv[k] !== 1'b1 || sw_rxd[k] !== e) begin
          failures++;
          $display("FAIL sweep_rx inst=%0d valid=%b got=%02h exp=%02h", k, sw_rxv[k], sw_rxd[k], e);
        end
      end
      n = 0;
      while (sw_csn[k] !== 1'b1 && n < 1000) begin
        step();
        n++;
      end
      checks += 2;
      if (sw_per_cnt[k] - pc0 != 28) begin failures++; $display("FAIL sweep_periods inst=%0d got=%0d exp=28", k, sw_per_cnt[k] - pc0); end
      if (sw_per_bad[k] != pb0) begin failures++; $display("FAIL sweep_period_len inst=%0d got=%0d bad exp=0", k, sw_per_bad[k] - pb0); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_wait();
    test_reset_abort();
    test_back_to_back();
    test_div_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1);
  end

endmodule
